// File: rtl/dmem_arb_pkg.sv
// Shared types and defaults for the data-memory arbiter.
package dmem_arb_pkg;

    localparam int unsigned DefaultAw = 6;
    localparam int unsigned DefaultDw = 32;
    localparam int unsigned CntW      = 4;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StPend = 2'd1,
        StAck  = 2'd2
    } arb_state_e;

endpackage

// File: rtl/dmem_arb_starve_ctr.sv
// Starvation guard: counts denied pending cycles and raises a one-cycle pipeline hold.
module dmem_arb_starve_ctr
    import dmem_arb_pkg::*;
#(
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic pend_denied,
    output logic cpu_hold
);

    localparam logic [CntW-1:0] CntLast = CntW'(STARVE_MAX - 1);
    localparam logic [CntW-1:0] CntSat  = '1;

    logic [CntW-1:0] cnt_q, cnt_d;
    logic            hold_q, hold_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (pend_denied && (cnt_q != CntSat)) begin
            cnt_d = cnt_q + 1'b1;
        end
        // Never hold two cycles in a row.
        hold_d = pend_denied & (cnt_q == CntLast) & ~hold_q;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q  <= '0;
            hold_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            hold_q <= hold_d;
        end
    end

    assign cpu_hold = hold_q;

endmodule

// File: rtl/dmem_arbiter.sv
// Data RAM arbiter: MEM stage has priority, debug port uses req/ack.
// Optional starvation guard enabled by defining DMEM_ARB_STARVE_EN.
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int unsigned AW         = DefaultAw,
    parameter int unsigned DW         = DefaultDw,
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          cpu_re,
    input  logic          cpu_we,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_wdata,
    output logic [DW-1:0] cpu_rdata,
    output logic          cpu_hold,
    input  logic          dbg_req,
    input  logic          dbg_we,
    input  logic [AW-1:0] dbg_addr,
    input  logic [DW-1:0] dbg_wdata,
    output logic          dbg_ack,
    output logic [DW-1:0] dbg_rdata,
    output logic [AW-1:0] ram_addr,
    output logic          ram_we,
    output logic [DW-1:0] ram_wdata,
    input  logic [DW-1:0] ram_rdata
);

    arb_state_e    state_q, state_d;
    logic [DW-1:0] dbg_rdata_q, dbg_rdata_d;
    logic          cpu_act, can_grant, grant, hold;

    assign cpu_act   = cpu_re | cpu_we;
    assign can_grant = dbg_req & ((state_q == StIdle) | (state_q == StPend));

`ifdef DMEM_ARB_STARVE_EN
    logic cnt_clr, pend_denied;

    // A hold cycle frees the RAM for the debug port; the pipeline replays next cycle.
    assign grant       = can_grant & (~cpu_act | hold);
    assign cnt_clr     = (state_q == StIdle) | grant;
    assign pend_denied = (state_q == StPend) & ~grant;

    dmem_arb_starve_ctr #(
        .STARVE_MAX(STARVE_MAX)
    ) u_starve_ctr (
        .clk        (clk),
        .reset      (reset),
        .clr        (cnt_clr),
        .pend_denied(pend_denied),
        .cpu_hold   (hold)
    );
`else
    logic unused_starve_max;

    assign grant             = can_grant & ~cpu_act;
    assign hold              = 1'b0;
    assign unused_starve_max = ^CntW'(STARVE_MAX);
`endif

    always_comb begin
        state_d     = state_q;
        dbg_rdata_d = dbg_rdata_q;
        if (grant) begin
            dbg_rdata_d = dbg_we ? dbg_wdata : ram_rdata;
        end
        unique case (state_q)
            StIdle: begin
                if (grant) begin
                    state_d = StAck;
                end else if (dbg_req) begin
                    state_d = StPend;
                end
            end
            StPend: begin
                if (grant) begin
                    state_d = StAck;
                end
            end
            StAck:   state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        if (grant) begin
            ram_addr  = dbg_addr;
            ram_we    = dbg_we;
            ram_wdata = dbg_wdata;
        end else begin
            ram_addr  = cpu_addr;
            ram_we    = cpu_we;
            ram_wdata = cpu_wdata;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= StIdle;
            dbg_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            dbg_rdata_q <= dbg_rdata_d;
        end
    end

    assign cpu_rdata = ram_rdata;
    assign cpu_hold  = hold;
    assign dbg_ack   = (state_q == StAck);
    assign dbg_rdata = dbg_rdata_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter; expectations follow DMEM_ARB_STARVE_EN when defined.
module tb_dmem_arbiter;

    localparam int unsigned AW = 6;
    localparam int unsigned DW = 32;

    logic          clk = 1'b0;
    logic          reset;
    logic          cpu_re, cpu_we;
    logic [AW-1:0] cpu_addr;
    logic [DW-1:0] cpu_wdata, cpu_rdata;
    logic          cpu_hold;
    logic          dbg_req, dbg_we;
    logic [AW-1:0] dbg_addr;
    logic [DW-1:0] dbg_wdata, dbg_rdata;
    logic          dbg_ack;
    logic [AW-1:0] ram_addr;
    logic          ram_we;
    logic [DW-1:0] ram_wdata, ram_rdata;

    logic [DW-1:0] mem     [64];
    logic [DW-1:0] ref_mem [64];

    logic [DW-1:0] dbg_q [$];
    logic [DW-1:0] cpu_q [$];
    bit            cpu_chk = 1'b0;
    int            checks  = 0;
    int            errors  = 0;
    int            hold_cnt = 0;

    dmem_arbiter #(
        .AW        (AW),
        .DW        (DW),
        .STARVE_MAX(4)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .cpu_re   (cpu_re),
        .cpu_we   (cpu_we),
        .cpu_addr (cpu_addr),
        .cpu_wdata(cpu_wdata),
        .cpu_rdata(cpu_rdata),
        .cpu_hold (cpu_hold),
        .dbg_req  (dbg_req),
        .dbg_we   (dbg_we),
        .dbg_addr (dbg_addr),
        .dbg_wdata(dbg_wdata),
        .dbg_ack  (dbg_ack),
        .dbg_rdata(dbg_rdata),
        .ram_addr (ram_addr),
        .ram_we   (ram_we),
        .ram_wdata(ram_wdata),
        .ram_rdata(ram_rdata)
    );

    always #5 clk = ~clk;

    // Single-port RAM model with asynchronous read.
    assign ram_rdata = mem[ram_addr];
    always @(posedge clk) begin
        if (ram_we) mem[ram_addr] <= ram_wdata;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: pops expected values whenever the DUT presents a response.
    always @(negedge clk) begin
        if (reset) begin
            if (cpu_hold) hold_cnt++;
            if (dbg_ack) begin
                if (dbg_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL dbg_ack_unexpected: got ack with data %h expected no ack",
                             dbg_rdata);
                end else begin
                    check("dbg_rdata", dbg_rdata, dbg_q.pop_front());
                end
            end
            if (cpu_chk && cpu_re) begin
                if (cpu_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL cpu_read_unexpected: got %h expected no read", cpu_rdata);
                end else begin
                    check("cpu_rdata", cpu_rdata, cpu_q.pop_front());
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic cpu_idle();
        cpu_re = 0; cpu_we = 0; cpu_addr = '0; cpu_wdata = '0;
    endtask

    task automatic dbg_issue(input bit we, input logic [AW-1:0] a, input logic [DW-1:0] d);
        dbg_req = 1; dbg_we = we; dbg_addr = a; dbg_wdata = d;
    endtask

    // Steps until dbg_ack; lat = cycles waited (0 on timeout), hb = hold seen the cycle before.
    task automatic wait_ack(input int budget, output int lat, output bit hb);
        bit prev_hold = 0;
        lat = 0;
        hb  = 0;
        for (int c = 1; c <= budget; c++) begin
            step();
            if (dbg_ack) begin
                lat = c;
                hb  = prev_hold;
                dbg_req = 0;
                return;
            end
            prev_hold = cpu_hold;
        end
    endtask

    initial begin
        int lat;
        bit hb;
        int h0;

        for (int i = 0; i < 64; i++) mem[i] = '0;
        reset = 0;
        cpu_idle();
        dbg_req = 0; dbg_we = 0; dbg_addr = '0; dbg_wdata = '0;
        step();
        step();
        check("rst_dbg_ack", 32'(dbg_ack), 32'd0);
        check("rst_dbg_rdata", dbg_rdata, 32'd0);
        check("rst_cpu_hold", 32'(cpu_hold), 32'd0);
        check("rst_state", 32'(dut.state_q), 32'd0);
        reset = 1;
        step();

        // Uncontended read.
        mem[5] = 32'h1234_5678;
        dbg_issue(0, 6'd5, '0);
        dbg_q.push_back(32'h1234_5678);
        wait_ack(10, lat, hb);
        check("t1_latency", 32'(lat), 32'd1);
        check("t1_cpu_hold", 32'(cpu_hold), 32'd0);
        step();

        // CPU write collides with debug read of the same word.
        cpu_we = 1; cpu_addr = 6'd3; cpu_wdata = 32'hDEAD_BEEF;
        dbg_issue(0, 6'd3, '0);
        #1;
        check("t2_ram_we_cpu", 32'(ram_we), 32'd1);
        check("t2_ram_wdata_cpu", ram_wdata, 32'hDEAD_BEEF);
        step();
        cpu_idle();
        check("t2_pend_no_ack", 32'(dbg_ack), 32'd0);
        check("t2_mem3", mem[3], 32'hDEAD_BEEF);
        dbg_q.push_back(32'hDEAD_BEEF);
        wait_ack(10, lat, hb);
        check("t2_latency", 32'(lat), 32'd1);
        step();

        // Debug write under continuous CPU reads.
        mem[10] = 32'h0000_0055;
        cpu_re = 1; cpu_addr = 6'd10;
        h0 = hold_cnt;
        dbg_issue(1, 6'd7, 32'hA5A5_A5A5);
`ifdef DMEM_ARB_STARVE_EN
        dbg_q.push_back(32'hA5A5_A5A5);
        wait_ack(20, lat, hb);
        check("t3_latency", 32'(lat), 32'd6);
        check("t3_hold_before_ack", 32'(hb), 32'd1);
        check("t3_hold_count", 32'(hold_cnt - h0), 32'd1);
        check("t3_mem7", mem[7], 32'hA5A5_A5A5);
`else
        wait_ack(100, lat, hb);
        check("t3_no_ack", 32'(lat), 32'd0);
        check("t3_hold_count", 32'(hold_cnt - h0), 32'd0);
        check("t3_mem7", mem[7], 32'd0);
        dbg_req = 0;
`endif

        // Reset while a request is pending.
        cpu_re = 1; cpu_addr = 6'd10;
        dbg_issue(0, 6'd5, '0);
        step();
        step();
        check("t5_pend", 32'(dut.state_q), 32'd1);
        reset = 0;
        #1;
        check("t5_rst_dbg_ack", 32'(dbg_ack), 32'd0);
        check("t5_rst_dbg_rdata", dbg_rdata, 32'd0);
        check("t5_rst_cpu_hold", 32'(cpu_hold), 32'd0);
        cpu_idle();
        dbg_req = 0;
        step();
        reset = 1;
        step();
        check("t5_idle_after", 32'(dut.state_q), 32'd0);
        check("t5_no_ack_after", 32'(dbg_ack), 32'd0);

        // Request held through ACK: one access per ack, second starts at N+2.
        dbg_issue(1, 6'd20, 32'h0F0F_0F0F);
        dbg_q.push_back(32'h0F0F_0F0F);
        dbg_q.push_back(32'h0F0F_0F0F);
        step();
        check("t4_ack1", 32'(dbg_ack), 32'd1);
        check("t4_ack_cycle_ram_we", 32'(ram_we), 32'd0);
        step();
        check("t4_gap", 32'(dbg_ack), 32'd0);
        check("t4_second_grant_we", 32'(ram_we), 32'd1);
        step();
        check("t4_ack2", 32'(dbg_ack), 32'd1);
        dbg_req = 0;
        step();
        check("t4_done", 32'(dbg_ack), 32'd0);
        check("t4_mem20", mem[20], 32'h0F0F_0F0F);

        // Back-to-back CPU write/read sweep against a reference model.
        h0 = hold_cnt;
        cpu_chk = 1;
        for (int i = 0; i < 64; i++) begin
            cpu_re = 0; cpu_we = 1; cpu_addr = AW'(i); cpu_wdata = 32'hC0DE_0000 | 32'(i);
            ref_mem[i] = cpu_wdata;
            step();
            cpu_re = 1; cpu_we = 0;
            cpu_q.push_back(ref_mem[i]);
            step();
        end
        cpu_idle();
        step();
        cpu_chk = 0;
        check("t6_hold_count", 32'(hold_cnt - h0), 32'd0);
        check("dbg_q_drained", 32'(dbg_q.size()), 32'd0);
        check("cpu_q_drained", 32'(cpu_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Shares the single-port data RAM between the pipeline MEM stage and a secondary debug/display requester. The MEM stage always has priority. The secondary port uses a req/ack handshake. An optional starvation guard forces a one-cycle pipeline hold so the secondary requester is eventually served. The block sits between the EX/MEM pipeline register and the data RAM, and its hold output feeds the hazard unit.

## Interface
- AW, 6, word-address width (RAM depth 2^AW words)
- DW, 32, data width
- STARVE_MAX, 4, consecutive denied cycles before a forced grant (1..15)

Ports:
- clk  input  1  pipeline clock; all state on rising edge
- reset  input  1  asynchronous, active-low reset
- cpu_re  input  1  MEM-stage read this cycle
- cpu_we  input  1  MEM-stage write this cycle
- cpu_addr  input  AW  MEM-stage word address
- cpu_wdata  input  DW  MEM-stage write data
- cpu_rdata  output  DW  read data to MEM/WB; combinational from ram_rdata
- cpu_hold  output  1  registered; freezes PC, IF/ID, ID/EX, EX/MEM for one cycle
- dbg_req  input  1  secondary request; held with addr/we/wdata until dbg_ack
- dbg_we  input  1  1 = write, 0 = read
- dbg_addr  input  AW  secondary word address
- dbg_wdata  input  DW  secondary write data
- dbg_ack  output  1  one-cycle completion pulse
- dbg_rdata  output  DW  registered read data, valid while dbg_ack = 1
- ram_addr  output  AW  to RAM address
- ram_we  output  1  to RAM write enable
- ram_wdata  output  DW  to RAM write data
- ram_rdata  input  DW  asynchronous RAM read data

## Operation
- The FSM has three states: IDLE, PEND, ACK.
- cpu_act = cpu_re | cpu_we.
- grant = dbg_req & (state is IDLE or PEND) & (!cpu_act | cpu_hold).
- RAM mux:
  - When grant = 1, ram_* carry dbg_addr, dbg_we and dbg_wdata.
  - Otherwise ram_* carry the cpu_* signals, and ram_we = cpu_we.
- IDLE:
  - grant goes to ACK and captures ram_rdata into dbg_rdata. On a write, dbg_rdata is loaded with dbg_wdata.
  - dbg_req & !grant goes to PEND.
- PEND:
  - grant goes to ACK with the same capture as IDLE.
  - Otherwise the state stays PEND and starve_cnt increments (saturating).
- ACK:
  - dbg_ack = 1.
  - dbg_req is ignored in this state.
  - The next state is always IDLE.
- Starvation: when state = PEND, the access is denied, and starve_cnt = STARVE_MAX-1, cpu_hold is set to 1 for the next cycle. In that cycle grant is forced and the CPU access is suppressed; the held pipeline replays it in the following cycle.
- starve_cnt clears on entering ACK and in IDLE.
- cpu_hold is never asserted two cycles in a row.
- Priority: the CPU always wins, except in a cpu_hold cycle.

## Timing
- Values after reset: state IDLE, dbg_ack 0, dbg_rdata 0, cpu_hold 0, starve_cnt 0.
- cpu_rdata and the RAM mux are combinational, so the MEM stage sees no added latency.
- Uncontended secondary access: dbg_req sampled in cycle N, dbg_ack in cycle N+1.
- Minimum secondary access spacing is 2 cycles: the requester may deassert or re-present dbg_req in N+2.
- Worst-case secondary latency under constant CPU traffic is STARVE_MAX+2 cycles from request to dbg_ack.
- dbg_req rising in the same cycle as a CPU access goes to PEND with no RAM side effect.
- Reset mid-transaction abandons the access: no ack is issued and the requester must re-issue. A write already clocked into the RAM stays written.

## Configuration
- DMEM_ARB_STARVE_EN
  - Defined: the starvation counter and cpu_hold are implemented as described above.
  - Undefined: cpu_hold is tied to 0, no counter exists, and grant requires !cpu_act. The secondary port may wait indefinitely.

## Structure
- Package dmem_arb_pkg holds the state encoding (IDLE=2'd0, PEND=2'd1, ACK=2'd2) and the AW/DW defaults.
- Sub-module dmem_arb_starve_ctr contains the saturating counter and the cpu_hold register. It is instantiated only under DMEM_ARB_STARVE_EN.

## Test plan
- CPU idle, secondary read, addr 5, RAM[5]=0x1234_5678 -> dbg_ack in the next cycle, dbg_rdata=0x1234_5678, cpu_hold 0.
- CPU writes 0xDEAD_BEEF to addr 3 in the same cycle that secondary reads addr 3 -> CPU write lands, state PEND; the next idle cycle grants the secondary and dbg_rdata=0xDEAD_BEEF.
- Continuous cpu_re, STARVE_MAX=4, secondary write 0xA5A5_A5A5 to addr 7 -> cpu_hold=1 in exactly one cycle, RAM[7]=0xA5A5_A5A5, dbg_ack in the following cycle. Without the macro: no ack after 100 cycles.
- dbg_req held through ACK -> only one access is performed per ack; the second access starts from IDLE at N+2.
- reset low while in PEND -> dbg_ack, dbg_rdata and cpu_hold are all 0; state is IDLE after release.
- Back-to-back CPU read/write to addr 0..63 with no secondary request -> cpu_rdata matches a reference memory model and cpu_hold stays 0.
